// File: rtl/upsampler_pkg.sv
// Shared types and width helpers for the linear interpolating upsampler.
package upsampler_pkg;

    typedef enum logic {
        S_WAIT = 1'b0,
        S_EMIT = 1'b1
    } state_t;

    // Accumulator holds prev scaled by RATIO plus one guard bit for the ramp.
    function automatic int acc_width(input int data_width, input int ratio);
        return data_width + $clog2(ratio) + 1;
    endfunction

endpackage

// File: rtl/interp_step_accum.sv
// Ramp generator: loads prev*RATIO and the step delta, adds delta per output beat,
// and presents acc >>> SHIFT (floor rounding) as the interpolated sample.
module interp_step_accum
    import upsampler_pkg::*;
#(
    parameter int DATA_WIDTH = 12,
    parameter int RATIO      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_load,
    input  logic                  i_step,
    input  logic [DATA_WIDTH-1:0] i_prev,
    input  logic [DATA_WIDTH-1:0] i_sample,
    output logic [DATA_WIDTH-1:0] o_data
);

    localparam int SHIFT = $clog2(RATIO);
    localparam int ACC_W = acc_width(DATA_WIDTH, RATIO);

    logic [ACC_W-1:0]      r_acc;
    logic [DATA_WIDTH:0]   r_delta;
    logic [ACC_W-1:0]      w_prev_ext;
    logic [ACC_W-1:0]      w_delta_ext;

    assign w_prev_ext  = {{(SHIFT + 1){i_prev[DATA_WIDTH-1]}}, i_prev};
    assign w_delta_ext = {{SHIFT{r_delta[DATA_WIDTH]}}, r_delta};

    // A load wins over a step: the final beat's increment is irrelevant once a new burst starts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc   <= '0;
            r_delta <= '0;
        end else if (i_load) begin
            r_acc   <= w_prev_ext << SHIFT;
            r_delta <= {i_sample[DATA_WIDTH-1], i_sample} - {i_prev[DATA_WIDTH-1], i_prev};
        end else if (i_step) begin
            r_acc   <= r_acc + w_delta_ext;
        end else begin
            r_acc   <= r_acc;
        end
    end

    // The ramp stays within [prev_old, new], so dropping the upper bits never overflows.
    assign o_data = r_acc[SHIFT +: DATA_WIDTH];

endmodule

// File: rtl/linear_interp_upsampler.sv
// Audio upsampler emitting RATIO samples per input; LINEAR_INTERP_EN selects a linear
// ramp from the previous sample, otherwise each burst is a zero-order hold of the new sample.
module linear_interp_upsampler
    import upsampler_pkg::*;
#(
    parameter int DATA_WIDTH = 12,
    parameter int RATIO      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data
);

    localparam int SHIFT   = $clog2(RATIO);
    localparam int PHASE_W = (SHIFT < 1) ? 1 : SHIFT;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [PHASE_W-1:0]   r_phase;
    logic [PHASE_W-1:0]   w_phase_nxt;
    logic [DATA_WIDTH-1:0] r_prev;
    logic                 w_out_fire;
    logic                 w_last;
    logic                 w_accept;

    assign out_valid  = (r_state == S_EMIT);
    assign w_out_fire = out_valid && out_ready;
    assign w_last     = (r_phase == PHASE_W'(RATIO - 1));
    // Accepting on the last beat keeps the output stream gap-free.
    assign in_ready   = (r_state == S_WAIT) || (w_out_fire && w_last);
    assign w_accept   = in_valid && in_ready;

    // Burst sequencing: start on accept, advance per output beat, idle after the last beat.
    always_comb begin
        w_state_nxt = r_state;
        w_phase_nxt = r_phase;
        case (r_state)
            S_WAIT: begin
                if (w_accept) begin
                    w_state_nxt = S_EMIT;
                    w_phase_nxt = '0;
                end else begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_EMIT: begin
                if (w_accept) begin
                    w_state_nxt = S_EMIT;
                    w_phase_nxt = '0;
                end else if (w_out_fire) begin
                    w_phase_nxt = r_phase + PHASE_W'(1);
                    w_state_nxt = w_last ? S_WAIT : S_EMIT;
                end else begin
                    w_state_nxt = S_EMIT;
                end
            end
            default: begin
                w_state_nxt = S_WAIT;
                w_phase_nxt = '0;
            end
        endcase
    end

    // State, phase and last-accepted-sample registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_WAIT;
            r_phase <= '0;
            r_prev  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_phase <= w_phase_nxt;
            if (w_accept) begin
                r_prev <= in_data;
            end else begin
                r_prev <= r_prev;
            end
        end
    end

`ifdef LINEAR_INTERP_EN
    logic [DATA_WIDTH-1:0] w_ramp_data;

    interp_step_accum #(
        .DATA_WIDTH (DATA_WIDTH),
        .RATIO      (RATIO)
    ) u_accum (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_load   (w_accept),
        .i_step   (w_out_fire),
        .i_prev   (r_prev),
        .i_sample (in_data),
        .o_data   (w_ramp_data)
    );

    assign out_data = w_ramp_data;
`else
    assign out_data = r_prev;
`endif

endmodule
